majority_vote_sched: RTL and testbench

Round-robin scheduler that shares one pair/triple (2-of-3 majority) detector among NREQ requester channels. Each requester presents three vote bits under a val/rdy handshake. Each cycle the block grants at most one channel and evaluates that channel's votes through the single detector. It returns a registered one-bit verdict, tagged with the channel index, on a single response port. The block sits between the per-channel redundant-sensor front ends and the downstream fault/decision logic, and also keeps a saturating count of non-unanimous votes.

---
 rtl/majority_vote_sched_pkg.sv | 18 +
 rtl/majority_vote_sched_if.sv | 27 ++
 rtl/majority_vote_sched_rr_arbiter.sv | 33 +++
 rtl/majority_vote_sched.sv | 74 +++++++
 tb/tb_majority_vote_sched.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/majority_vote_sched_pkg.sv
// Shared constants and vote helpers for the majority-vote scheduler and other vote consumers.
package majority_vote_sched_pkg;

    localparam int unsigned NREQ_DEFAULT = 4;
    localparam int unsigned VOTE_W       = 3;
    localparam int unsigned CNT_W        = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // 2-of-3 majority, same gate structure as the legacy pair/triple detector
    function automatic logic maj3(input logic [VOTE_W-1:0] v);
        return (v[0] & v[1]) | ((v[0] | v[1]) & v[2]);
    endfunction

    function automatic logic unanimous(input logic [VOTE_W-1:0] v);
        return (v == 3'b000) || (v == 3'b111);
    endfunction

endpackage

// File: rtl/majority_vote_sched_if.sv
// Request/response bus between requester channels, the scheduler and the downstream consumer.
interface majority_vote_sched_if
    import majority_vote_sched_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEFAULT
);
    localparam int unsigned CW = $clog2(NREQ);

    logic [NREQ-1:0]        req_val;
    logic [VOTE_W*NREQ-1:0] req_bits;
    logic [NREQ-1:0]        req_rdy;
    logic                   resp_val;
    logic                   resp_rdy;
    logic [CW-1:0]          resp_chan;
    logic                   resp_vote;
    logic [CNT_W-1:0]       disagree_cnt;

    modport master (
        output req_val, req_bits, resp_rdy,
        input  req_rdy, resp_val, resp_chan, resp_vote, disagree_cnt
    );

    modport slave (
        input  req_val, req_bits, resp_rdy,
        output req_rdy, resp_val, resp_chan, resp_vote, disagree_cnt
    );
endinterface

// File: rtl/majority_vote_sched_rr_arbiter.sv
// Round-robin arbiter: first asserted request at or after i_ptr, wrapping modulo NREQ.
module rr_arbiter #(
    parameter int unsigned NREQ = 4
) (
    input  logic [NREQ-1:0]          i_req,
    input  logic [$clog2(NREQ)-1:0]  i_ptr,
    output logic [NREQ-1:0]          o_grant,
    output logic [$clog2(NREQ)-1:0]  o_idx,
    output logic                     o_any
);
    localparam int unsigned CW = $clog2(NREQ);

    logic [CW:0] w_pos;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_pos   = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_pos = {1'b0, i_ptr} + (CW+1)'(k);
            if (w_pos >= (CW+1)'(NREQ)) begin
                w_pos = w_pos - (CW+1)'(NREQ);
            end
            if (!o_any && i_req[w_pos[CW-1:0]]) begin
                o_grant[w_pos[CW-1:0]] = 1'b1;
                o_idx                  = w_pos[CW-1:0];
                o_any                  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/majority_vote_sched.sv
// Shares one 2-of-3 majority detector among NREQ channels; registered single-entry response
// plus a saturating count of non-unanimous votes.
module majority_vote_sched
    import majority_vote_sched_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    majority_vote_sched_if.slave  bus
);
    localparam int unsigned CW = $clog2(NREQ);

    logic [CW-1:0]     r_ptr;
    logic              r_resp_val;
    logic [CW-1:0]     r_resp_chan;
    logic              r_resp_vote;
    logic [CNT_W-1:0]  r_cnt;

    logic [NREQ-1:0]   w_grant;
    logic [CW-1:0]     w_idx;
    logic              w_any;
    logic              w_out_free;
    logic              w_accept;
    logic [VOTE_W-1:0] w_sel_bits;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .i_req   (bus.req_val),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    // Output slot can take a new response if empty or draining this edge
    assign w_out_free  = ~r_resp_val | bus.resp_rdy;
    assign w_accept    = w_any & w_out_free & ~reset;
    assign bus.req_rdy = reset ? '0 : (w_grant & {NREQ{w_out_free}});

    always_comb begin
        w_sel_bits = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_idx == CW'(i)) begin
                w_sel_bits = bus.req_bits[VOTE_W*i +: VOTE_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr       <= '0;
            r_resp_val  <= 1'b0;
            r_resp_chan <= '0;
            r_resp_vote <= 1'b0;
            r_cnt       <= '0;
        end else if (w_accept) begin
            r_resp_val  <= 1'b1;
            r_resp_chan <= w_idx;
            r_resp_vote <= maj3(w_sel_bits);
            r_ptr       <= (w_idx == CW'(NREQ-1)) ? '0 : w_idx + CW'(1);
            if (!unanimous(w_sel_bits) && (r_cnt != CNT_MAX)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end else if (r_resp_val && bus.resp_rdy) begin
            r_resp_val <= 1'b0;
        end
    end

    assign bus.resp_val     = r_resp_val;
    assign bus.resp_chan    = r_resp_chan;
    assign bus.resp_vote    = r_resp_vote;
    assign bus.disagree_cnt = r_cnt;

endmodule

// File: tb/tb_majority_vote_sched.sv
// Self-checking bench: directed vector table, saturation run, and random traffic vs a reference model.
module tb_majority_vote_sched;

    localparam int NREQ = 4;

    logic clk;
    logic reset;

    majority_vote_sched_if #(.NREQ(NREQ)) bus();

    majority_vote_sched #(.NREQ(NREQ)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int m_val  = 0;
    int m_chan = 0;
    int m_vote = 0;
    int m_cnt  = 0;
    int m_ptr  = 0;

    typedef struct {
        logic        rst;
        logic [3:0]  val;
        logic [11:0] bits;
        logic        rdy;
        logic [3:0]  e_rdy;
        logic        e_val;
        logic [1:0]  e_chan;
        logic        e_vote;
        logic [7:0]  e_cnt;
    } vec_t;

    vec_t tbl[21];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: check req_rdy before the edge, advance the model, check registered outputs after.
    task automatic tick(output logic [3:0] rdy_seen);
        int g;
        int free;
        int votes;
        logic [2:0] b;
        logic [3:0] exp_rdy;
        #1;
        free = (m_val == 0 || bus.resp_rdy) ? 1 : 0;
        g = -1;
        for (int k = 0; k < NREQ; k++) begin
            int c;
            c = (m_ptr + k) % NREQ;
            if (g < 0 && bus.req_val[c]) g = c;
        end
        exp_rdy = 4'b0000;
        if (!reset && free == 1 && g >= 0) exp_rdy[g] = 1'b1;
        rdy_seen = bus.req_rdy;
        check("req_rdy", int'(bus.req_rdy), int'(exp_rdy));
        b = 3'b000;
        if (g >= 0) b = bus.req_bits[3*g +: 3];
        @(posedge clk);
        if (reset) begin
            m_val = 0; m_chan = 0; m_vote = 0; m_cnt = 0; m_ptr = 0;
        end else if (free == 1 && g >= 0) begin
            votes  = $countones(b);
            m_val  = 1;
            m_chan = g;
            m_vote = (votes >= 2) ? 1 : 0;
            m_ptr  = (g + 1) % NREQ;
            if (votes != 0 && votes != 3 && m_cnt < 255) m_cnt++;
        end else if (m_val == 1 && bus.resp_rdy) begin
            m_val = 0;
        end
        #1;
        check("resp_val", int'(bus.resp_val), m_val);
        check("resp_chan", int'(bus.resp_chan), m_chan);
        check("resp_vote", int'(bus.resp_vote), m_vote);
        check("disagree_cnt", int'(bus.disagree_cnt), m_cnt);
    endtask

    task automatic drive(input logic rst, input logic [3:0] val, input logic [11:0] bits,
                         input logic rdy);
        reset        = rst;
        bus.req_val  = val;
        bus.req_bits = bits;
        bus.resp_rdy = rdy;
    endtask

    logic [3:0] seen;

    initial begin
        //                rst   val    bits     rdy  e_rdy  val  ch  vote cnt
        tbl[0]  = '{1'b1, 4'hF, 12'h000, 1'b1, 4'h0, 1'b0, 2'd0, 1'b0, 8'd0}; // reset
        tbl[1]  = '{1'b0, 4'h4, 12'h0C0, 1'b1, 4'h4, 1'b1, 2'd2, 1'b1, 8'd1}; // single ch2 011
        tbl[2]  = '{1'b0, 4'h0, 12'h000, 1'b1, 4'h0, 1'b0, 2'd2, 1'b1, 8'd1}; // drain
        tbl[3]  = '{1'b1, 4'hF, 12'hFFF, 1'b1, 4'h0, 1'b0, 2'd0, 1'b0, 8'd0}; // reset
        tbl[4]  = '{1'b0, 4'hF, 12'hFFF, 1'b1, 4'h1, 1'b1, 2'd0, 1'b1, 8'd0}; // contention
        tbl[5]  = '{1'b0, 4'hF, 12'hFFF, 1'b1, 4'h2, 1'b1, 2'd1, 1'b1, 8'd0};
        tbl[6]  = '{1'b0, 4'hF, 12'hFFF, 1'b1, 4'h4, 1'b1, 2'd2, 1'b1, 8'd0};
        tbl[7]  = '{1'b0, 4'hF, 12'hFFF, 1'b1, 4'h8, 1'b1, 2'd3, 1'b1, 8'd0};
        tbl[8]  = '{1'b0, 4'hF, 12'h000, 1'b1, 4'h1, 1'b1, 2'd0, 1'b0, 8'd0};
        tbl[9]  = '{1'b0, 4'hF, 12'h000, 1'b0, 4'h0, 1'b1, 2'd0, 1'b0, 8'd0}; // backpressure x5
        tbl[10] = '{1'b0, 4'hF, 12'h000, 1'b0, 4'h0, 1'b1, 2'd0, 1'b0, 8'd0};
        tbl[11] = '{1'b0, 4'hF, 12'h000, 1'b0, 4'h0, 1'b1, 2'd0, 1'b0, 8'd0};
        tbl[12] = '{1'b0, 4'hF, 12'h000, 1'b0, 4'h0, 1'b1, 2'd0, 1'b0, 8'd0};
        tbl[13] = '{1'b0, 4'hF, 12'h000, 1'b0, 4'h0, 1'b1, 2'd0, 1'b0, 8'd0};
        tbl[14] = '{1'b0, 4'hF, 12'h000, 1'b1, 4'h2, 1'b1, 2'd1, 1'b0, 8'd0}; // drain+accept
        tbl[15] = '{1'b0, 4'h1, 12'h000, 1'b1, 4'h1, 1'b1, 2'd0, 1'b0, 8'd0}; // ptr -> 1
        tbl[16] = '{1'b0, 4'h9, 12'h601, 1'b1, 4'h8, 1'b1, 2'd3, 1'b1, 8'd1}; // skip to ch3
        tbl[17] = '{1'b0, 4'h9, 12'h601, 1'b1, 4'h1, 1'b1, 2'd0, 1'b0, 8'd2}; // then ch0
        tbl[18] = '{1'b0, 4'h0, 12'h000, 1'b0, 4'h0, 1'b1, 2'd0, 1'b0, 8'd2}; // hold pending
        tbl[19] = '{1'b1, 4'hF, 12'h000, 1'b0, 4'h0, 1'b0, 2'd0, 1'b0, 8'd0}; // reset mid-op
        tbl[20] = '{1'b0, 4'hF, 12'h000, 1'b1, 4'h1, 1'b1, 2'd0, 1'b0, 8'd0}; // first grant ch0

        drive(1'b1, 4'h0, 12'h000, 1'b0);
        for (int i = 0; i < 21; i++) begin
            drive(tbl[i].rst, tbl[i].val, tbl[i].bits, tbl[i].rdy);
            tick(seen);
            check($sformatf("vec%0d_req_rdy", i), int'(seen), int'(tbl[i].e_rdy));
            check($sformatf("vec%0d_resp_val", i), int'(bus.resp_val), int'(tbl[i].e_val));
            check($sformatf("vec%0d_resp_chan", i), int'(bus.resp_chan), int'(tbl[i].e_chan));
            check($sformatf("vec%0d_resp_vote", i), int'(bus.resp_vote), int'(tbl[i].e_vote));
            check($sformatf("vec%0d_cnt", i), int'(bus.disagree_cnt), int'(tbl[i].e_cnt));
        end

        // Saturation: 300 non-unanimous accepts, counter must stop at 255
        for (int i = 0; i < 300; i++) begin
            drive(1'b0, 4'h1, 12'h001, 1'b1);
            tick(seen);
            check("sat_vote", int'(bus.resp_vote), 0);
        end
        check("sat_cnt_final", int'(bus.disagree_cnt), 255);

        // Random traffic with occasional reset
        drive(1'b1, 4'h0, 12'h000, 1'b1);
        tick(seen);
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(99) == 0), 4'($urandom), 12'($urandom),
                  ($urandom_range(3) != 0));
            tick(seen);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
